prog_ctr: RTL and testbench

Program counter and fetch sequencer for the 8-bit single-cycle core. It sits directly downstream of the ALU and consumes its `taken` flag together with decoder branch/halt controls. Each cycle it drives the instruction-memory address and steps the program through the states IDLE, RUN and DONE. Branch targets come from a small branch-target lookup table indexed by the instruction's immediate field.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/branch_lut.sv | 16 +
 rtl/prog_ctr.sv | 84 ++++++++
 tb/tb_prog_ctr.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit core's fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    localparam int PC_W_DEF   = 10;
    localparam int LUT_W_DEF  = 5;
    localparam int START_ADDR = 0;

    // Regenerated by the assembler flow; entry 31 points at the last word of memory.
    localparam logic [PC_W_DEF-1:0] BR_LUT [2**LUT_W_DEF] = '{
        10'h000, 10'h020, 10'h040, 10'h060, 10'h080, 10'h0A0, 10'h0C0, 10'h0E0,
        10'h100, 10'h120, 10'h140, 10'h160, 10'h180, 10'h1A0, 10'h1C0, 10'h1E0,
        10'h200, 10'h220, 10'h240, 10'h260, 10'h280, 10'h2A0, 10'h2C0, 10'h2E0,
        10'h300, 10'h320, 10'h340, 10'h360, 10'h380, 10'h3A0, 10'h3C0, 10'h3FF
    };

endpackage

// File: rtl/branch_lut.sv
// Branch-target ROM: maps the instruction's immediate index to a jump address.
// Latency: combinational.
// Backpressure: none; always valid.
module branch_lut
    import cpu_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic [LUT_W-1:0] target_idx,
    output logic [PC_W-1:0]  target
);

    assign target = PC_W'(BR_LUT[target_idx]);

endmodule

// File: rtl/prog_ctr.sv
// Program counter and fetch sequencer (IDLE -> RUN -> DONE).
// Latency: next pc visible one cycle after the sampling edge; zero branch penalty.
// Backpressure: stall freezes pc and the cycle counter while in RUN.
module prog_ctr
    import cpu_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int LUT_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch,
    input  logic             taken,
    input  logic [LUT_W-1:0] target_idx,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt
);

    pc_state_t        state;
    logic [PC_W-1:0]  br_target;
    logic [CNT_W-1:0] cnt_next;

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_branch_lut (
        .target_idx (target_idx),
        .target     (br_target)
    );

    // Saturating increment: the counter sticks at all-ones rather than wrapping.
    assign cnt_next = (cyc_cnt == {CNT_W{1'b1}}) ? cyc_cnt : cyc_cnt + CNT_W'(1);
    assign fetch_en = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            done    <= 1'b0;
            cyc_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= PC_W'(START_ADDR);
                    if (start) begin
                        state   <= RUN;
                        cyc_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        cyc_cnt <= cnt_next;
                        if (halt) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (branch && taken) begin
                            pc <= br_target;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Leaving DONE needs start low, so a held start never reruns.
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr.sv
// Self-checking bench for prog_ctr: directed scenarios plus randomized traffic
// against a behavioural model; a second instance with a 4-bit counter covers saturation.
module tb_prog_ctr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, stall, halt, branch, taken;
    logic [4:0] target_idx;
    logic [9:0] pc, pc4;
    logic       fetch_en, fetch_en4, done, done4;
    logic [15:0] cyc_cnt;
    logic [3:0]  cyc_cnt4;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: running/done flags, address and an unbounded cycle count.
    bit     m_run, m_done;
    int     m_pc;
    longint m_cnt;

    prog_ctr #(.PC_W(10), .LUT_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch(branch), .taken(taken), .target_idx(target_idx),
        .pc(pc), .fetch_en(fetch_en), .done(done), .cyc_cnt(cyc_cnt)
    );

    prog_ctr #(.PC_W(10), .LUT_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch(branch), .taken(taken), .target_idx(target_idx),
        .pc(pc4), .fetch_en(fetch_en4), .done(done4), .cyc_cnt(cyc_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lut_ref(input int idx);
        return (idx == 31) ? 'h3FF : idx * 32;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
        end else if (m_run) begin
            if (!stall) begin
                m_cnt++;
                if (halt) begin
                    m_run = 0; m_done = 1;
                end else if (branch && taken) begin
                    m_pc = lut_ref(int'(target_idx));
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                end
            end
        end else if (m_done) begin
            if (!start) m_done = 0;
        end else begin
            m_pc = 0;
            if (start) begin
                m_run = 1; m_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("done", 32'(done), 32'(m_done));
        check("fetch_en", 32'(fetch_en), 32'(m_run));
        check("cyc_cnt", 32'(cyc_cnt), 32'(sat(m_cnt, 16)));
        check("pc4", 32'(pc4), 32'(m_pc));
        check("done4", 32'(done4), 32'(m_done));
        check("cyc_cnt4", 32'(cyc_cnt4), 32'(sat(m_cnt, 4)));
    endtask

    task automatic quiet();
        rst_n = 1; start = 0; stall = 0; halt = 0; branch = 0; taken = 0; target_idx = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); stall = 1'($urandom); halt = 1'($urandom);
            branch = 1'($urandom); taken = 1'($urandom); target_idx = 5'($urandom);
            tick();
        end
        quiet();
    endtask

    task automatic begin_run();
        quiet();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic run_to(input int addr);
        for (int i = 0; i < 64 && m_pc != addr; i++) tick();
        check("reach_pc", 32'(pc), 32'(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
        #2;

        // Reset values
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fetch_en", 32'(fetch_en), 32'd0);
        check("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);

        // Sequential fetch, halt at 5
        begin_run();
        for (int k = 0; k < 5; k++) begin
            check("seq_pc", 32'(pc), 32'(k));
            tick();
        end
        check("seq_pc", 32'(pc), 32'd5);
        halt = 1;
        tick();
        halt = 0;
        check("seq_done", 32'(done), 32'd1);
        check("seq_hold_pc", 32'(pc), 32'd5);
        check("seq_cnt", 32'(cyc_cnt), 32'd6);
        tick();

        // Taken branch then not-taken branch at pc 3
        begin_run();
        run_to(3);
        branch = 1; taken = 1; target_idx = 5'd2;
        tick();
        check("br_taken", 32'(pc), 32'h040);
        quiet();
        do_reset();
        begin_run();
        run_to(3);
        branch = 1; taken = 0; target_idx = 5'd2;
        tick();
        check("br_not_taken", 32'(pc), 32'd4);
        branch = 0; taken = 1;
        tick();
        check("taken_no_branch", 32'(pc), 32'd5);
        quiet();

        // Stall priority at pc 7
        run_to(7);
        stall = 1; halt = 1; branch = 1; taken = 1; target_idx = 5'd5;
        tick();
        check("stall_pc", 32'(pc), 32'd7);
        check("stall_cnt", 32'(cyc_cnt), 32'd7);
        check("stall_no_done", 32'(done), 32'd0);
        stall = 0; branch = 0; taken = 0;
        tick();
        check("stall_release_done", 32'(done), 32'd1);
        quiet();
        tick();

        // Wrap at top of memory
        begin_run();
        branch = 1; taken = 1; target_idx = 5'd31;
        tick();
        check("wrap_hi", 32'(pc), 32'h3FF);
        quiet();
        tick();
        check("wrap_lo", 32'(pc), 32'h000);
        do_reset();

        // Saturation on the narrow counter
        begin_run();
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt4", 32'(cyc_cnt4), 32'd15);
        check("sat_cnt16", 32'(cyc_cnt), 32'd20);
        do_reset();

        // Reset mid-run
        begin_run();
        run_to(9);
        rst_n = 0;
        tick();
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_fetch_en", 32'(fetch_en), 32'd0);
        quiet();

        // Done handshake with start held high
        start = 1;
        tick();
        halt = 1;
        tick();
        halt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_hold", 32'(done), 32'd1);
            check("done_no_rerun", 32'(fetch_en), 32'd0);
        end
        start = 0;
        tick();
        check("done_drop", 32'(done), 32'd0);
        check("idle_fetch_en", 32'(fetch_en), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            start      = ($urandom_range(0, 3) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            halt       = ($urandom_range(0, 29) == 0);
            branch     = ($urandom_range(0, 3) == 0);
            taken      = 1'($urandom);
            target_idx = 5'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
